// File: rtl/arb_pkg.sv
// Shared definitions for the N-requester arbiter: mode constants,
// FSM state encoding and a one-hot to index helper.
package arb_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Largest supported requester count and the index width it needs.
    localparam int MAX_N = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        ST_IDLE,
        ST_GRANTED
    } arb_state_e;

    // Index of the set bit in a one-hot vector; zero when no bit is set.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/arbiter_rr_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface arbiter_rr_if #(
    parameter int N = 4
) ();

    localparam int IDW = $clog2(N);

    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;

    modport master (
        output req,
        input  grant,
        input  grant_id,
        input  grant_valid
    );

    modport slave (
        input  req,
        output grant,
        output grant_id,
        output grant_valid
    );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection: rotate the masked requests so the scan
// start lands on bit 0, take the lowest set bit, rotate the result back.
module arb_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [N-1:0]         mask_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    input  logic                 mode_i,
    output logic [N-1:0]         win_o,
    output logic                 any_o
);

    localparam int IDW = $clog2(N);

    logic [N-1:0]   cand;
    logic [N-1:0]   rot;
    logic [N-1:0]   pe;
    logic [IDW-1:0] start;

    assign cand  = req_i & mask_i;
    assign any_o = |cand;

    // Scan start: index 0 for fixed priority, ptr+1 (mod N) for round-robin.
    always_comb begin
        start = '0;
        if (!mode_i && (ptr_i != IDW'(N - 1))) begin
            start = ptr_i + IDW'(1);
        end
    end

    assign rot = N'({cand, cand} >> start);

    // Lowest set bit of the rotated candidates.
    always_comb begin
        logic found;
        pe    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (rot[i] && !found) begin
                pe[i] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign win_o = N'(({pe, pe} << start) >> N);

endmodule

// File: rtl/arbiter_rr.sv
// N-requester non-preemptive arbiter with registered one-hot grant,
// round-robin or fixed priority, and an optional hold timeout.
module arbiter_rr
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MODE     = 0,
    parameter int MAX_HOLD = 0
) (
    input  logic clk,
    input  logic reset,
    arbiter_rr_if.slave bus
);

    localparam int IDW = $clog2(N);
    localparam int HW  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

    arb_state_e     state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HW-1:0]  hold_q, hold_d;

    logic [N-1:0]   mask;
    logic [N-1:0]   win;
    logic           any;
    logic           hreq;
    logic           others;
    logic           timeout;
    logic           mode_fixed;

    assign mode_fixed = (MODE == MODE_FIXED);

    // grant_q is one-hot on the holder while GRANTED, so it doubles as the holder mask.
    assign hreq    = |(bus.req & grant_q);
    assign others  = |(bus.req & ~grant_q);
    assign timeout = (MAX_HOLD > 0) && (hold_q == HW'(MAX_HOLD));

    // Exclude the holder from selection only on a forced timeout release.
    always_comb begin
        mask = '1;
        if ((state_q == ST_GRANTED) && hreq && timeout && others) begin
            mask = ~grant_q;
        end
    end

    arb_pick #(
        .N(N)
    ) u_pick (
        .req_i  (bus.req),
        .mask_i (mask),
        .ptr_i  (ptr_q),
        .mode_i (mode_fixed),
        .win_o  (win),
        .any_o  (any)
    );

    // State, grant, pointer and hold counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= IDW'(N - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state: acquire from idle, hold, timeout hand-off, or release.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    state_d = ST_GRANTED;
                    grant_d = win;
                    ptr_d   = IDW'(onehot_to_idx(MAX_N'(win)));
                    hold_d  = HW'(1);
                end
            end
            ST_GRANTED: begin
                if (hreq && timeout && others) begin
                    grant_d = win;
                    ptr_d   = IDW'(onehot_to_idx(MAX_N'(win)));
                    hold_d  = HW'(1);
                end else if (hreq) begin
                    if ((MAX_HOLD > 0) && !timeout) begin
                        hold_d = hold_q + HW'(1);
                    end
                end else if (any) begin
                    grant_d = win;
                    ptr_d   = IDW'(onehot_to_idx(MAX_N'(win)));
                    hold_d  = HW'(1);
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = IDW'(onehot_to_idx(MAX_N'(grant_q)));
    assign bus.grant_valid = |grant_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// Directed bench for arbiter_rr: three instances cover round-robin,
// round-robin with hold timeout, and fixed priority.
module tb_arbiter_rr;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    arbiter_rr_if #(.N(4)) if0 ();
    arbiter_rr_if #(.N(4)) if4 ();
    arbiter_rr_if #(.N(4)) if1 ();

    arbiter_rr #(.N(4), .MODE(0), .MAX_HOLD(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
    arbiter_rr #(.N(4), .MODE(0), .MAX_HOLD(4)) u4 (.clk(clk), .reset(reset), .bus(if4));
    arbiter_rr #(.N(4), .MODE(1), .MAX_HOLD(0)) u1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-hot-or-zero invariant on every instance, sampled mid-cycle.
    always @(negedge clk) begin
        total_cnt++;
        if (!$onehot0(if0.grant) || !$onehot0(if4.grant) || !$onehot0(if1.grant)) begin
            $display("FAIL onehot0 t=%0t grants=%b %b %b required one-hot or zero",
                     $time, if0.grant, if4.grant, if1.grant);
        end else begin
            pass_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset   = 1'b1;
        if0.req = '0;
        if4.req = '0;
        if1.req = '0;
        #2;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        tick();
        total_cnt++;
        if (if0.grant !== 4'b0000 || if4.grant !== 4'b0000 || if1.grant !== 4'b0000) begin
            $display("FAIL reset_grant got=%b %b %b required 0000", if0.grant, if4.grant, if1.grant);
        end else pass_cnt++;
        total_cnt++;
        if (if0.grant_id !== 2'd0 || if0.grant_valid !== 1'b0) begin
            $display("FAIL reset_id_valid got id=%0d valid=%b required 0/0", if0.grant_id, if0.grant_valid);
        end else pass_cnt++;
        if0.req = 4'b1111;
        tick();
        total_cnt++;
        if (if0.grant !== 4'b0000) begin
            $display("FAIL reset_held got=%b required 0000", if0.grant);
        end else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (if0.grant !== 4'b0001 || if0.grant_id !== 2'd0 || if0.grant_valid !== 1'b1) begin
            $display("FAIL reset_release got=%b id=%0d valid=%b required 0001/0/1",
                     if0.grant, if0.grant_id, if0.grant_valid);
        end else pass_cnt++;
        #3;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (if0.grant !== 4'b0000 || if0.grant_valid !== 1'b0) begin
            $display("FAIL reset_async got=%b valid=%b required 0000/0", if0.grant, if0.grant_valid);
        end else pass_cnt++;
        #1;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (if0.grant !== 4'b0001 || if0.grant_id !== 2'd0) begin
            $display("FAIL reset_rearm got=%b id=%0d required 0001/0", if0.grant, if0.grant_id);
        end else pass_cnt++;
        if0.req = 4'b0000;
        tick();
        total_cnt++;
        if (if0.grant !== 4'b0000) begin
            $display("FAIL reset_drop got=%b required 0000", if0.grant);
        end else pass_cnt++;
    endtask

    task automatic test_single();
        if0.req = 4'b0100;
        tick();
        total_cnt++;
        if (if0.grant !== 4'b0100 || if0.grant_id !== 2'd2 || if0.grant_valid !== 1'b1) begin
            $display("FAIL single_grant got=%b id=%0d valid=%b required 0100/2/1",
                     if0.grant, if0.grant_id, if0.grant_valid);
        end else pass_cnt++;
        if0.req = 4'b0000;
        tick();
        total_cnt++;
        if (if0.grant !== 4'b0000 || if0.grant_id !== 2'd0 || if0.grant_valid !== 1'b0) begin
            $display("FAIL single_release got=%b id=%0d valid=%b required 0000/0/0",
                     if0.grant, if0.grant_id, if0.grant_valid);
        end else pass_cnt++;
    endtask

    task automatic test_rotation();
        logic [3:0] reqs [4];
        logic [3:0] exps [4];
        logic [1:0] ids  [4];
        reqs = '{4'b1011, 4'b1010, 4'b1001, 4'b0011};
        exps = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        ids  = '{2'd0, 2'd1, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if0.req = reqs[i];
            tick();
            total_cnt++;
            if (if0.grant !== exps[i] || if0.grant_id !== ids[i]) begin
                $display("FAIL rotation[%0d] got=%b id=%0d required %b/%0d",
                         i, if0.grant, if0.grant_id, exps[i], ids[i]);
            end else pass_cnt++;
        end
        if0.req = 4'b0000;
        tick();
    endtask

    task automatic test_timeout();
        logic [3:0] exp;
        do_reset();
        if4.req = 4'b0011;
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp = (i <= 4) ? 4'b0001 : ((i <= 8) ? 4'b0010 : 4'b0001);
            total_cnt++;
            if (if4.grant !== exp) begin
                $display("FAIL timeout_cycle[%0d] got=%b required %b", i, if4.grant, exp);
            end else pass_cnt++;
        end
        if4.req = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            tick();
            total_cnt++;
            if (if4.grant !== 4'b0001) begin
                $display("FAIL timeout_alone[%0d] got=%b required 0001", i, if4.grant);
            end else pass_cnt++;
        end
        if4.req = 4'b0000;
        tick();
        total_cnt++;
        if (if4.grant !== 4'b0000) begin
            $display("FAIL timeout_release got=%b required 0000", if4.grant);
        end else pass_cnt++;
    endtask

    task automatic test_fixed();
        do_reset();
        if1.req = 4'b1100;
        tick();
        total_cnt++;
        if (if1.grant !== 4'b0100 || if1.grant_id !== 2'd2) begin
            $display("FAIL fixed_first got=%b id=%0d required 0100/2", if1.grant, if1.grant_id);
        end else pass_cnt++;
        if1.req = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (if1.grant !== 4'b0100) begin
                $display("FAIL fixed_nopreempt[%0d] got=%b required 0100", i, if1.grant);
            end else pass_cnt++;
        end
        if1.req = 4'b1010;
        tick();
        total_cnt++;
        if (if1.grant !== 4'b0010 || if1.grant_id !== 2'd1) begin
            $display("FAIL fixed_handoff got=%b id=%0d required 0010/1", if1.grant, if1.grant_id);
        end else pass_cnt++;
        if1.req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        if0.req = 4'b1000;
        tick();
        total_cnt++;
        if (if0.grant !== 4'b1000 || if0.grant_id !== 2'd3) begin
            $display("FAIL midrst_setup got=%b id=%0d required 1000/3", if0.grant, if0.grant_id);
        end else pass_cnt++;
        if0.req = 4'b1001;
        #3;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (if0.grant !== 4'b0000 || if0.grant_id !== 2'd0 || if0.grant_valid !== 1'b0) begin
            $display("FAIL midrst_clear got=%b id=%0d valid=%b required 0000/0/0",
                     if0.grant, if0.grant_id, if0.grant_valid);
        end else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++;
        if (if0.grant !== 4'b0001 || if0.grant_id !== 2'd0) begin
            $display("FAIL midrst_ptr got=%b id=%0d required 0001/0", if0.grant, if0.grant_id);
        end else pass_cnt++;
        if0.req = 4'b0000;
        tick();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        if0.req   = '0;
        if4.req   = '0;
        if1.req   = '0;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_fixed();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
